// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage that sits ahead of the ID decoders. It owns the PC,
//   drives a request/ready instruction-memory port and presents a registered
//   {valid, pc, inst} to ID. A one-entry hold buffer absorbs a word that
//   arrives while ID is stalled. ID can redirect the fetch with branch_en.
//
//   Build option: define IF_DELAY_SLOT_EN for MIPS-style delay-slot behaviour
//   (the instruction after a branch is still delivered). Leave it undefined to
//   squash that instruction so that the next delivered instruction is at the
//   branch target.
//
// Parameters
//   RESET_PC       first fetch address after reset (word aligned)
//   PC_STEP        sequential PC increment in bytes
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            synchronous active-low reset
//   inst_req       fetch request, held high until inst_ready
//   inst_addr      fetch address (current pc), stable while inst_req=1
//   inst_ready     memory response strobe, qualified by inst_req
//   inst_rdata     instruction word, valid with inst_ready
//   stall          ID/EX cannot accept, hold the id_* outputs
//   branch_en      redirect request from ID, ignored while stall=1
//   branch_target  redirect address, bits [1:0] are forced to zero
//   id_valid       id_pc/id_inst hold a real instruction
//   id_pc          PC of the instruction presented to ID
//   id_inst        instruction presented to ID, zero (NOP) when id_valid=0
//
// States
//   S_IDLE | one cycle after reset release, no request
//   S_REQ  | request outstanding at inst_addr = pc
//   S_HOLD | a word is parked in the hold buffer, waiting for stall=0
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic [31:0] inst_rdata,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

`ifdef IF_DELAY_SLOT_EN
  localparam logic DS_EN = 1'b1;
`else
  localparam logic DS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state,         w_state_nxt;
  logic [31:0] r_pc,            w_pc_nxt;
  logic [31:0] r_redir_target,  w_redir_target_nxt;
  logic        r_redir_pending, w_redir_pending_nxt;
  logic        r_drop,          w_drop_nxt;
  logic        r_hold_valid,    w_hold_valid_nxt;
  logic [31:0] r_hold_pc,       w_hold_pc_nxt;
  logic [31:0] r_hold_inst,     w_hold_inst_nxt;
  logic        r_id_valid,      w_id_valid_nxt;
  logic [31:0] r_id_pc,         w_id_pc_nxt;
  logic [31:0] r_id_inst,       w_id_inst_nxt;

  logic        w_accept;
  logic        w_branch;
  logic [31:0] w_target;

  assign inst_req  = (r_state == S_REQ);
  assign inst_addr = r_pc;
  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_inst   = r_id_inst;

  assign w_accept = inst_req & inst_ready;
  assign w_branch = branch_en & ~stall;
  assign w_target = {branch_target[31:2], 2'b00};

  always_comb begin
    w_state_nxt         = r_state;
    w_pc_nxt            = r_pc;
    w_redir_target_nxt  = r_redir_target;
    w_redir_pending_nxt = r_redir_pending;
    w_drop_nxt          = r_drop;
    w_hold_valid_nxt    = r_hold_valid;
    w_hold_pc_nxt       = r_hold_pc;
    w_hold_inst_nxt     = r_hold_inst;
    w_id_valid_nxt      = r_id_valid;
    w_id_pc_nxt         = r_id_pc;
    w_id_inst_nxt       = r_id_inst;

    // ID consumed whatever it had; show a bubble unless something new arrives.
    if (!stall) begin
      w_id_valid_nxt = 1'b0;
      w_id_inst_nxt  = '0;
    end

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end

      S_REQ: begin
        if (w_accept) begin
          w_redir_pending_nxt = 1'b0;
          // A branch seen in the accept cycle redirects immediately; otherwise
          // an earlier redirect recorded while waiting takes effect now.
          if (w_branch) begin
            w_pc_nxt = w_target;
          end else if (r_redir_pending) begin
            w_pc_nxt = r_redir_target;
          end else begin
            w_pc_nxt = r_pc + PC_STEP;
          end

          if (r_drop) begin
            w_drop_nxt = 1'b0;
          end else if (!w_branch || DS_EN) begin
            if (!stall) begin
              w_id_valid_nxt = 1'b1;
              w_id_pc_nxt    = r_pc;
              w_id_inst_nxt  = inst_rdata;
            end else begin
              w_hold_valid_nxt = 1'b1;
              w_hold_pc_nxt    = r_pc;
              w_hold_inst_nxt  = inst_rdata;
              w_state_nxt      = S_HOLD;
            end
          end
        end else if (w_branch) begin
          // inst_addr must stay put while the request is open, so the new
          // target is parked until this fetch completes.
          w_redir_target_nxt  = w_target;
          w_redir_pending_nxt = 1'b1;
          if (!DS_EN) begin
            w_drop_nxt = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (!stall) begin
          w_state_nxt      = S_REQ;
          w_hold_valid_nxt = 1'b0;
          // pc already moved past the held word, so a redirect here is direct.
          if (branch_en) begin
            w_pc_nxt = w_target;
          end
          if (!branch_en || DS_EN) begin
            w_id_valid_nxt = r_hold_valid;
            w_id_pc_nxt    = r_hold_pc;
            w_id_inst_nxt  = r_hold_inst;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_pc            <= RESET_PC;
      r_redir_target  <= '0;
      r_redir_pending <= 1'b0;
      r_drop          <= 1'b0;
      r_hold_valid    <= 1'b0;
      r_hold_pc       <= '0;
      r_hold_inst     <= '0;
      r_id_valid      <= 1'b0;
      r_id_pc         <= '0;
      r_id_inst       <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_redir_target  <= w_redir_target_nxt;
      r_redir_pending <= w_redir_pending_nxt;
      r_drop          <= w_drop_nxt;
      r_hold_valid    <= w_hold_valid_nxt;
      r_hold_pc       <= w_hold_pc_nxt;
      r_hold_inst     <= w_hold_inst_nxt;
      r_id_valid      <= w_id_valid_nxt;
      r_id_pc         <= w_id_pc_nxt;
      r_id_inst       <= w_id_inst_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RDATA_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_ready(inst_ready), .inst_rdata(inst_rdata),
    .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
  );

  int n_tests  = 0;
  int n_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Program-order model: the next PC that ID must consume, plus a parked
  // branch target while a delay-slot instruction is still owed.
  logic [31:0] m_exp_pc;
  bit          m_ds_pend;
  logic [31:0] m_ds_tgt;
  logic [31:0] deliv_q[$];

  // Inputs applied at the last edge and outputs seen just before it.
  bit          p_rst, p_stall, p_req, p_ready, p_id_valid;
  logic [31:0] p_addr, p_id_pc, p_id_inst;

  // One clock: observe outputs, drive inputs for the next edge, update model.
  task automatic step(input bit rst_i, input bit stall_i, input bit br_i,
                      input logic [31:0] tgt_i, input bit rdy_i);
    bit br_eff;
    if (!p_rst) begin
      check("rst_req",   inst_req,  0);
      check("rst_valid", id_valid,  0);
      check("rst_id_pc", id_pc,     0);
      check("rst_inst",  id_inst,   0);
      check("rst_addr",  inst_addr, RESET_PC);
    end else begin
      if (p_stall) begin
        check("frz_valid", id_valid, p_id_valid);
        check("frz_pc",    id_pc,    p_id_pc);
        check("frz_inst",  id_inst,  p_id_inst);
      end
      if (p_req && !p_ready) begin
        check("hold_req",  inst_req,  1);
        check("hold_addr", inst_addr, p_addr);
      end
      if (!id_valid) check("nop_inst", id_inst, 0);
    end

    // A redirect only makes sense for a real instruction that ID is taking;
    // with stall=1 it is driven freely because it must be ignored.
    br_eff = br_i && (stall_i || (id_valid && !m_ds_pend));

    rst           = rst_i;
    stall         = stall_i;
    branch_en     = br_eff;
    branch_target = tgt_i;
    inst_ready    = rdy_i;
    inst_rdata    = inst_addr ^ RDATA_KEY;

    if (!rst_i) begin
      m_exp_pc  = RESET_PC;
      m_ds_pend = 1'b0;
    end else if (id_valid && !stall_i) begin
      deliv_q.push_back(id_pc);
      check("seq_pc",   id_pc,   m_exp_pc);
      check("seq_inst", id_inst, m_exp_pc ^ RDATA_KEY);
      if (br_eff) begin
`ifdef IF_DELAY_SLOT_EN
        m_ds_pend = 1'b1;
        m_ds_tgt  = tgt_i & ~32'd3;
        m_exp_pc  = m_exp_pc + 32'd4;
`else
        m_exp_pc  = tgt_i & ~32'd3;
`endif
      end else if (m_ds_pend) begin
        m_exp_pc  = m_ds_tgt;
        m_ds_pend = 1'b0;
      end else begin
        m_exp_pc = m_exp_pc + 32'd4;
      end
    end

    p_rst      = rst_i;
    p_stall    = stall_i;
    p_ready    = rdy_i;
    p_req      = inst_req;
    p_addr     = inst_addr;
    p_id_valid = id_valid;
    p_id_pc    = id_pc;
    p_id_inst  = id_inst;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  task automatic run_until_valid(output bit found);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (id_valid) found = 1'b1;
      else step(1, 0, 0, 0, 1);
    end
  endtask

  initial begin
    bit   found;
    int   idx, cnt, wcnt, n_before;
    logic [31:0] tgt;

    rst = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
    inst_ready = 1'b0; inst_rdata = '0;
    m_exp_pc = RESET_PC; m_ds_pend = 1'b0; m_ds_tgt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    p_rst = 1'b0; p_stall = 1'b0; p_req = 1'b0; p_ready = 1'b0;
    p_addr = '0; p_id_valid = 1'b0; p_id_pc = '0; p_id_inst = '0;

    // Reset values, then zero-wait streaming from RESET_PC.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 1);
      if (i == 1) check("t1_first_pc", id_pc, RESET_PC);
      if (i >= 1) check("t1_valid", id_valid, 1);
    end

    // Two wait cycles per fetch: one delivery every three cycles.
    wcnt = 0; cnt = 0;
    for (int i = 0; i < 24; i++) begin
      bit rdy;
      rdy = inst_req && (wcnt == 2);
      if (inst_req) wcnt = rdy ? 0 : wcnt + 1;
      step(1, 0, 0, 0, rdy);
      if (i >= 12 && i < 21 && id_valid) cnt++;
    end
    check("t2_rate", cnt, 3);

    // Downstream stall with zero-wait memory.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 1);
      check("t3_req_off", inst_req, 0);
    end
    step(1, 0, 0, 0, 1);
    check("t3_hold_out", id_valid, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);

    // Branch to 0x100 (low bits set to check masking) while pc=8 is in flight.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (id_valid && id_pc == 32'h4) found = 1'b1;
      else step(1, 0, 0, 0, 1);
    end
    check("t4_found", found, 1);
    idx = deliv_q.size();
    step(1, 0, 1, 32'h0000_0103, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
`ifdef IF_DELAY_SLOT_EN
    check("t4_slot",   deliv_q[idx + 1], 32'h8);
    check("t4_target", deliv_q[idx + 2], 32'h100);
`else
    check("t4_target", deliv_q[idx + 1], 32'h100);
`endif

    // Branch under stall is ignored; then wrap from 0xFFFF_FFFC to 0.
    step(1, 1, 1, 32'h0000_0200, 1);
    step(1, 1, 1, 32'h0000_0200, 1);
    run_until_valid(found);
    check("t5_valid", found, 1);
    idx = deliv_q.size();
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1);
    found = 1'b0;
    for (int k = idx; k + 1 < deliv_q.size(); k++)
      if (deliv_q[k] == 32'hFFFF_FFFC && deliv_q[k + 1] == 32'h0) found = 1'b1;
    check("t5_wrap", found, 1);

    // Reset asserted in a cycle where ready arrives.
    check("t6_req_busy", inst_req, 1);
    step(0, 0, 0, 0, 1);
    idx = deliv_q.size();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    check("t6_restart", (deliv_q.size() > idx) ? deliv_q[idx] : 32'hDEAD_BEEF, RESET_PC);

    // Randomised traffic against the program-order model.
    n_before = deliv_q.size();
    for (int i = 0; i < 3000; i++) begin
      bit r, s, b, y;
      r   = ($urandom_range(0, 299) != 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 5) == 0);
      y   = ($urandom_range(0, 9) < 6);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      step(r, s, b, tgt, y);
    end
    check("rand_progress", (deliv_q.size() - n_before >= 300) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule
